// File: rtl/ram_req_adapter.sv
// ============================================================================
// Module   : ram_req_adapter
// Purpose  : Valid/ready front end for a single-port 32-bit on-chip RAM.
//            Accepts one transaction at a time, checks range and alignment,
//            turns byte-masked writes into read-modify-write sequences and
//            returns read data captured from the RAM's one-cycle read port.
// Ports    : clk, rst_n                          clock, async active-low reset
//            req_valid/req_ready/req_addr/req_we/req_wdata/req_be  request
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err                 response
//            ram_addr/ram_wdata/ram_write_en/ram_read_en/ram_rdata RAM side
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_req_adapter #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_write_en,
    output logic        ram_read_en,
    input  logic [31:0] ram_rdata
);

    // Window size in bytes, one bit wider so 4*MEM_DEPTH cannot overflow.
    localparam logic [32:0] WINDOW_BYTES = 33'(MEM_DEPTH) * 33'd4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RDW  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t      state;
    logic        we_lat;
    logic [3:0]  be_lat;

    logic [31:0] offset;
    logic        addr_bad;
    logic [31:0] merged;

    // Unsigned check: an address below the base wraps to a huge offset and
    // is also rejected by the explicit >= test.
    assign offset   = req_addr - ADDR_BASE;
    assign addr_bad = (req_addr[1:0] != 2'b00)
                    || (req_addr < ADDR_BASE)
                    || ({1'b0, offset} >= WINDOW_BYTES);

    // Byte merge for partial writes: enabled lanes from the latched write
    // data (held in ram_wdata), the rest from the word just read.
    always_comb begin
        merged = ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (be_lat[i]) begin
                merged[8*i +: 8] = ram_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_lat       <= 1'b0;
            be_lat       <= 4'h0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_err      <= 1'b0;
            ram_addr     <= 32'h0;
            ram_wdata    <= 32'h0;
            ram_write_en <= 1'b0;
            ram_read_en  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ram_addr  <= offset;
                        we_lat    <= req_we;
                        be_lat    <= req_be;
                        ram_wdata <= req_wdata;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        if (addr_bad) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (!req_we) begin
                            ram_read_en <= 1'b1;
                            state       <= RD;
                        end else if (req_be == 4'hF) begin
                            ram_write_en <= 1'b1;
                            state        <= WR;
                        end else if (req_be == 4'h0) begin
                            // Nothing to write: acknowledge straight away.
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            ram_read_en <= 1'b1;
                            state       <= RD;
                        end
                    end
                end
                RD: begin
                    ram_read_en <= 1'b0;
                    state       <= RDW;
                end
                RDW: begin
                    if (we_lat) begin
                        ram_wdata    <= merged;
                        ram_write_en <= 1'b1;
                        state        <= WR;
                    end else begin
                        rsp_rdata <= ram_rdata;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WR: begin
                    ram_write_en <= 1'b0;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    ram_read_en  <= 1'b0;
                    ram_write_en <= 1'b0;
                    rsp_valid    <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ram_req_adapter.md
# ram_req_adapter

Request/response front end for the single-port on-chip RAM. It accepts one CPU/bus transaction at a time over a valid/ready interface and checks the address range and alignment. It converts byte-masked writes into read-modify-write sequences, drives the RAM's `addr`/`wdata`/`write_en`/`read_en`, and captures the RAM's one-cycle-latency `rdata`. It sits directly upstream of the RAM, between the interconnect and the memory array.

## Interface
- `ADDR_BASE`, 32'h0000_0000, byte address of RAM word 0; must be 4-byte aligned.
- `MEM_DEPTH`, 16384, RAM depth in 32-bit words; in-range window is `[ADDR_BASE, ADDR_BASE + 4*MEM_DEPTH)`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  adapter can accept a request.
- `req_addr`  in  32  byte address.
- `req_we`  in  1  1 = write, 0 = read.
- `req_wdata`  in  32  write data.
- `req_be`  in  4  byte enables; bit i covers `wdata[8i+7:8i]`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  out-of-range or misaligned request.
- `ram_addr`  out  32  byte offset into the RAM, `req_addr - ADDR_BASE`.
- `ram_wdata`  out  32  word to write.
- `ram_write_en`  out  1  RAM write strobe.
- `ram_read_en`  out  1  RAM read strobe.
- `ram_rdata`  in  32  RAM read data, valid on the cycle after `ram_read_en` is sampled.

## Operation
- Only one transaction is outstanding at a time. `req_ready = (state == IDLE)`.
- On acceptance (`req_valid && req_ready`), latch addr, we, wdata and be. Then pick the path:
  - Error (`addr[1:0] != 0` or address outside the window) → RESP, with `rsp_err = 1` and `rsp_rdata = 0`. No RAM strobe is issued.
  - Read → RD.
  - Write with `be == 4'hF` → WR.
  - Write with `be == 4'h0` → RESP, with `rsp_err = 0` and no RAM strobe.
  - Other partial write → RD.
- RD: `ram_read_en = 1` for exactly one cycle, then → RDW.
- RDW: `ram_rdata` is valid in this state.
  - Read: capture `ram_rdata` into `rsp_rdata`, then → RESP.
  - Partial write: merge. Byte i of the merged word comes from the latched wdata if `be[i]`, otherwise from `ram_rdata`. Store the merged word in the write-data register, then → WR.
- WR: `ram_write_en = 1` for exactly one cycle, with `ram_wdata` set to the full or merged word, then → RESP.
- RESP: `rsp_valid = 1`, with `rsp_rdata` and `rsp_err` held stable until `rsp_ready`. On the handshake → IDLE.
- `ram_addr` holds the latched offset in every state except IDLE. In IDLE it is don't-care; the implementation drives the last latched value.
- `ram_read_en` and `ram_write_en` are never high together and are 0 outside RD and WR.
- Range check is unsigned 32-bit: `addr >= ADDR_BASE` and `(addr - ADDR_BASE) < 4*MEM_DEPTH`. Wrap-around below the base counts as out of range.

## Timing
- Reset (async, `rst_n = 0`) puts the block in IDLE with the following output values:
  - `req_ready` = 1 once `rst_n` is high.
  - `rsp_valid` = 0, `rsp_err` = 0, `rsp_rdata` = 0.
  - `ram_read_en` = 0, `ram_write_en` = 0, `ram_wdata` = 0, `ram_addr` = 0.
- Reset mid-transaction aborts it with no response. If the abort lands in WR, that RAM write may or may not complete.
- Latency counts from the accept edge E to the first cycle `rsp_valid` is high:
  - error or `be == 0`: E+1
  - full write: E+2
  - read: E+3
  - partial write: E+4
- With `rsp_ready` held high, the next request is accepted on the cycle after the RESP handshake. Sustained throughput is one read per 4 cycles.
- Back-pressure on `rsp_ready` stalls in RESP indefinitely with outputs stable. `req_ready` stays 0 throughout.

## Test plan
- Reset, then with `ADDR_BASE = 0`: write addr 0x10, data 0xDEADBEEF, be 0xF, then read 0x10. Required: `ram_write_en` pulses once with `ram_addr = 0x10`, and the read response is 0xDEADBEEF with `rsp_err = 0` at E+3.
- Pre-load word 0x20 with 0x11223344, then write data 0xAABBCCDD with be 0x5. Required: RD, then WR with `ram_wdata = 0x11BB33DD`, and a subsequent read returns 0x11BB33DD.
- Read addr 0x6 (misaligned) and read `4*MEM_DEPTH` (one past the end). Both give `rsp_err = 1` and `rsp_rdata = 0` at E+1, with no RAM strobe.
- Hold `rsp_ready = 0` for 5 cycles after a read. Required: `rsp_valid` and `rsp_rdata` stay stable and `req_ready = 0`; the handshake returns the block to IDLE next cycle.
- Assert `rst_n = 0` asynchronously while in RDW of a partial write. Required: outputs go to reset values immediately, no `ram_write_en` pulse occurs, and the RAM word is unchanged.
- Write with `be = 0` → response at E+1 with `rsp_err = 0` and no RAM strobe.
